// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: valid/ready request in, fixed wait states, valid/ready response out.
// Optional one-line fetch buffer is enabled with `define IMEM_LINE_BUFFER_EN.
module instr_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH_WORDS));
  endfunction

  logic          load_ok;
  logic [AW-1:0] load_idx;
  logic          accept;
  logic          req_err;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          lb_hit;
  logic [31:0]   lb_word;

  assign load_ok  = load_we && addr_ok(load_addr);
  assign load_idx = load_addr[AW+1:2];
  assign accept   = req_valid && (state_q == S_IDLE) && !flush;
  assign req_err  = !addr_ok(req_addr);

  // With zero wait states the read happens on the accept edge, before addr_q holds the address.
  assign rd_idx  = (state_q == S_IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
  assign rd_word = (load_ok && (load_idx == rd_idx)) ? load_data : mem_q[rd_idx];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (req_err) begin
            err_d   = 1'b1;
            instr_d = 32'd0;
            state_d = S_RESP;
          end else begin
            err_d = 1'b0;
            if (lb_hit) begin
              instr_d = lb_word;
              state_d = S_RESP;
            end else if (WAIT_STATES == 0) begin
              instr_d = rd_word;
              state_d = S_RESP;
            end else begin
              cnt_d   = 4'(WAIT_STATES - 1);
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          instr_d = rd_word;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // A flush wins over rsp_ready: the response is discarded, not delivered.
        if (flush || rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      err_q   <= 1'b0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      instr_q <= instr_d;
    end
  end

  // NOTE: the memory array has no reset; its contents come only from the load port.
  always_ff @(posedge clk) begin
    if (load_ok) mem_q[load_idx] <= load_data;
  end

`ifdef IMEM_LINE_BUFFER_EN
  logic        lb_valid_q, lb_valid_d;
  logic [27:0] lb_tag_q, lb_tag_d;
  logic [31:0] lb_data_q [4];
  logic [31:0] lb_line_words [4];
  logic        lb_fill;

  // A load in the same cycle as a lookup would leave the buffered copy stale, so it forces a miss.
  assign lb_hit  = lb_valid_q && (lb_tag_q == req_addr[31:4])
                   && !(load_ok && (load_addr[31:4] == lb_tag_q));
  assign lb_word = lb_data_q[req_addr[3:2]];

  assign lb_tag_d = (state_q == S_IDLE) ? req_addr[31:4] : addr_q[31:4];
  assign lb_fill  = (state_q != S_RESP) && (state_d == S_RESP) && !err_d
                    && !((state_q == S_IDLE) && lb_hit);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lb_line_words[i] = (load_ok && (load_idx == {rd_idx[AW-1:2], 2'(i)}))
                         ? load_data : mem_q[{rd_idx[AW-1:2], 2'(i)}];
    end
  end

  always_comb begin
    lb_valid_d = lb_valid_q;
    if (load_ok && (load_addr[31:4] == lb_tag_q)) lb_valid_d = 1'b0;
    if (lb_fill) lb_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lb_valid_q <= 1'b0;
    else      lb_valid_q <= lb_valid_d;
  end

  always_ff @(posedge clk) begin
    if (lb_fill) begin
      lb_tag_q <= lb_tag_d;
      for (int i = 0; i < 4; i++) lb_data_q[i] <= lb_line_words[i];
    end
  end
`else
  assign lb_hit  = 1'b0;
  assign lb_word = 32'd0;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_instr = instr_q;
  assign rsp_addr  = addr_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: stimulus queues expected responses, a negedge monitor checks them.
module tb_instr_mem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int WAIT_STATES = 2;
  localparam int MISS_LAT    = 1 + WAIT_STATES;
`ifdef IMEM_LINE_BUFFER_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = MISS_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = 32'd0;
  logic [31:0] load_data = 32'd0;
  logic        busy;

  instr_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_STATES(WAIT_STATES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    int          issue_cyc;
    int          lat;
    bit          drop;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  // Monitor: negedge sampling sees the inputs that the next posedge will act on.
  bit   prev_valid = 1'b0;
  int   rise_cyc   = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        rise_cyc = cyc;
        if (sb_q.size() == 0) check("unexpected_rsp_valid", 1'b1, 1'b0);
      end
      if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (flush) begin
          check("dropped_rsp_expected_drop", 1'b1, e.drop);
        end else begin
          check("delivered_rsp_not_drop", 1'b0, e.drop);
          check("rsp_instr", rsp_instr, e.instr);
          check("rsp_addr", rsp_addr, e.addr);
          check("rsp_err", rsp_err, e.err);
          if (e.lat >= 0) check("rsp_latency", rise_cyc - e.issue_cyc, e.lat);
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // All stimulus tasks start and end at posedge + #1.
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input bit push, input logic [31:0] ei,
                       input logic ee, input int lat, input bit drop);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("issue_wait_req_ready_timeout", 1'b0, 1'b1);
    req_valid = 1'b1; req_addr = a;
    if (push) sb_q.push_back('{instr: ei, addr: a, err: ee, issue_cyc: cyc, lat: lat, drop: drop});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) check(name, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !req_ready) && n < 100) begin @(posedge clk); #1; n++; end
    if (sb_q.size() != 0 || !req_ready) check("drain_timeout", 1'b0, 1'b1);
  endtask

  logic [31:0] preload [8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};

  initial begin
    #2 rst = 1'b0;
    #1;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_instr", rsp_instr, 32'd0);
    check("reset_rsp_addr", rsp_addr, 32'd0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) load(32'(i * 4), preload[i]);

    // Basic fetch and both error kinds.
    issue(32'h8, 1, 32'h33, 1'b0, MISS_LAT, 0);
    drain();
    issue(32'h6, 1, 32'h0, 1'b1, 1, 0);
    drain();
    issue(32'(4 * DEPTH_WORDS), 1, 32'h0, 1'b1, 1, 0);
    drain();

    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1; req_addr = 32'h8; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_blocks_accept", busy, 1'b0);

    // Back-pressure: response stable for 5 cycles; a load in RESP must not disturb it.
    rsp_ready = 1'b0;
    issue(32'h14, 1, 32'h66, 1'b0, MISS_LAT, 0);
    wait_valid("hold_wait_rsp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_instr", rsp_instr, 32'h66);
      check("hold_rsp_addr", rsp_addr, 32'h14);
      check("hold_req_ready", req_ready, 1'b0);
      load_we   = (i == 0);
      load_addr = 32'h14;
      load_data = 32'h5A5A;
      @(posedge clk); #1;
    end
    load_we   = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("consume_req_ready", req_ready, 1'b1);

    // Next request accepted the cycle after consumption; a load during WAIT is returned.
    issue(32'h1C, 1, 32'hAB, 1'b0, MISS_LAT, 0);
    load(32'h1C, 32'hAB);
    drain();

    // Flush one cycle into WAIT: never answered.
    issue(32'h20, 0, 32'h0, 1'b0, 0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_wait_req_ready", req_ready, 1'b1);
    check("flush_wait_busy", busy, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    // Flush in RESP together with rsp_ready: response dropped.
    issue(32'h0, 1, 32'h11, 1'b0, -1, 1);
    wait_valid("flush_resp_wait_rsp_valid_timeout");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_resp_rsp_valid", rsp_valid, 1'b0);
    check("flush_resp_queue_empty", 32'(sb_q.size()), 32'd0);

    // Reset asserted mid-WAIT takes effect immediately.
    issue(32'h24, 0, 32'h0, 1'b0, 0, 0);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_wait_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_wait_req_ready", req_ready, 1'b1);
    check("rst_mid_wait_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    issue(32'h4, 1, 32'h22, 1'b0, MISS_LAT, 0);
    drain();

    // Misaligned and out-of-range loads are ignored.
    load(32'h0, 32'h11);
    load(32'h2, 32'hDEAD);
    load(32'(4 * DEPTH_WORDS), 32'hBEEF);
    issue(32'h0, 1, 32'h11, 1'b0, MISS_LAT, 0);
    drain();
    issue(32'hC, 1, 32'h44, 1'b0, HIT_LAT, 0);
    drain();
    load(32'h4, 32'h99);
    issue(32'h4, 1, 32'h99, 1'b0, MISS_LAT, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
